// File: rtl/spi_led_pkg.sv
// ----------------------------------------------------------------------------
// spi_led_pkg
//  Shared types and constants for the SPI LED slave.
//  - state_t : frame FSM states
//  - LED_W   : LED count on the Basys 3 bank (default frame length)
//  - CNT_W   : bit counter width able to hold LED_W+1 (over-length marker)
// ----------------------------------------------------------------------------
package spi_led_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT
  } state_t;

  localparam int LED_W = 16;

  // The counter must reach data_w+1 so an over-length frame stays distinguishable.
  function automatic int bit_cnt_width(input int data_w);
    return $clog2(data_w + 2);
  endfunction

  localparam int CNT_W = bit_cnt_width(LED_W);

endpackage

// File: rtl/sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
//  Brings an asynchronous pin into the clk domain through a flip-flop chain
//  and flags its rising/falling transitions for one clk.
//  Parameters: STAGES - synchronizer depth (>= 2)
//  Ports:
//    clk   in  system clock
//    rst_n in  asynchronous active-low reset
//    din   in  asynchronous pin
//    level out synchronized level
//    rise  out 1-clk pulse on 0->1 of the synchronized level
//    fall  out 1-clk pulse on 1->0 of the synchronized level
// ----------------------------------------------------------------------------
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_led_slave.sv
// ----------------------------------------------------------------------------
// spi_led_slave
//  SPI mode-0 slave receiving one LED word per chip-select frame and driving
//  the LED bank. The previously committed word is shifted back on MISO during
//  the same frame. All SPI pins are oversampled in the clk domain.
//  Optional feature macro: SPI_WDOG_EN - when defined, a watchdog replaces the
//  LED pattern with a scrolling counter after WDOG_CYCLES clks without a
//  valid frame.
//  Ports:
//    clk          in  system clock (100 MHz)
//    rst_n        in  asynchronous active-low reset
//    spi_sclk     in  SPI clock, idle low
//    spi_cs_n     in  SPI chip select, active low
//    spi_mosi     in  master-out data, MSB first
//    spi_miso     out slave-out data, MSB first, 0 outside a frame
//    led          out LED drive, bit i -> LD i
//    frame_valid  out 1-clk pulse when a DATA_W-bit frame is committed
//    frame_err    out 1-clk pulse when a frame ends with the wrong bit count
//    wdog_timeout out high while the fallback pattern is shown
// ----------------------------------------------------------------------------
module spi_led_slave
  import spi_led_pkg::*;
#(
  parameter int DATA_W      = LED_W,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] led,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              wdog_timeout
);

  localparam int              CW       = bit_cnt_width(DATA_W);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DATA_W);
  localparam logic [CW-1:0]   SAT_CNT  = CW'(DATA_W + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI goes through the same depth so its level lines up with the sclk edge.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t            state, state_nx;
  logic              do_start, do_rx, do_tx, do_commit, do_error, do_end;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shadow;
  logic [DATA_W-1:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_IDLE;
    else        state <= state_nx;
  end

  // A chip-select edge takes priority over an sclk edge seen on the same clk.
  always_comb begin
    state_nx  = state;
    do_start  = 1'b0;
    do_rx     = 1'b0;
    do_tx     = 1'b0;
    do_commit = 1'b0;
    do_error  = 1'b0;
    do_end    = 1'b0;
    unique case (state)
      ST_WAIT_IDLE: begin
        if (cs_lvl) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          do_start = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          do_end   = 1'b1;
          state_nx = ST_IDLE;
          if (bit_cnt == FULL_CNT) do_commit = 1'b1;
          else                     do_error  = 1'b1;
        end else begin
          do_rx = sclk_rise;
          do_tx = sclk_fall;
        end
      end
      default: state_nx = ST_WAIT_IDLE;
    endcase
  end

  // Shift registers, bit counter, MISO driver and the committed LED word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shadow   <= '0;
      led_q       <= '0;
      spi_miso    <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= do_commit;
      frame_err   <= do_error;
      if (do_start) begin
        tx_shadow <= led_q;
        bit_cnt   <= '0;
        spi_miso  <= led_q[DATA_W-1];
      end
      if (do_rx) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_lvl};
        if (bit_cnt != SAT_CNT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (do_tx) begin
        tx_shadow <= {tx_shadow[DATA_W-2:0], 1'b0};
        spi_miso  <= (bit_cnt < FULL_CNT) ? tx_shadow[DATA_W-2] : 1'b0;
      end
      if (do_end)    spi_miso <= 1'b0;
      if (do_commit) led_q    <= rx_shift;
    end
  end

`ifdef SPI_WDOG_EN
  localparam int                WDOG_W   = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES - 1);
  localparam int                FB_W     = 27;
  localparam int                FB_USED  = DATA_W - 1;

  logic [WDOG_W-1:0]       wdog_cnt;
  logic [FB_W-1:0]         fb_cnt;
  logic [FB_W-FB_USED-1:0] fb_low_unused;

  // Watchdog restarts on every commit and parks at its maximum; the scroll
  // counter free-runs so the fallback pattern keeps moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      fb_cnt   <= '0;
    end else begin
      fb_cnt <= fb_cnt + 1'b1;
      if (do_commit)                wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_timeout  = (wdog_cnt == WDOG_MAX);
  assign led           = wdog_timeout ? {fb_cnt[FB_W-1 -: FB_USED], fb_cnt[FB_W-1]} : led_q;
  assign fb_low_unused = fb_cnt[FB_W-FB_USED-1:0];
`else
  localparam int wdog_unused_cycles = WDOG_CYCLES;

  assign wdog_timeout = 1'b0;
  assign led          = led_q;
`endif

endmodule

// File: tb/tb_spi_led_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_led_slave
//  Directed bench for spi_led_slave: acts as the SPI master, counts the
//  frame_valid/frame_err pulses and compares LED, readback and status values
//  against hand-computed expectations. Watchdog section follows SPI_WDOG_EN.
// ----------------------------------------------------------------------------
module tb_spi_led_slave;

  localparam int DATA_W = 16;
  localparam int WDOG   = 1000;
  localparam int HALF10 = 50;
  localparam int HALF12 = 40;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              spi_sclk = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [DATA_W-1:0] led;
  logic              frame_valid;
  logic              frame_err;
  logic              wdog_timeout;

  int checks      = 0;
  int fails       = 0;
  int valid_count = 0;
  int err_count   = 0;
  int cyc         = 0;

  spi_led_slave #(
    .DATA_W(DATA_W), .SYNC_STAGES(2), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .led(led),
    .frame_valid(frame_valid), .frame_err(frame_err), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  // Status pulses are tallied on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (frame_valid) valid_count++;
    if (frame_err)   err_count++;
  end

  // Reference for the fallback scroll counter: clks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Clocks nbits of word (MSB first) and captures MISO at every rising edge.
  task automatic shiftBits(input logic [31:0] word, input int nbits, input int half,
                           output logic [31:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = word[nbits-1-i];
      #half;
      rd = {rd[30:0], spi_miso};
      spi_sclk = 1'b1;
      #half;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int nbits, input int half,
                               output logic [31:0] rd);
    spi_cs_n = 1'b0;
    shiftBits(word, nbits, half, rd);
    #half;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #200;
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] word;
    logic [31:0] model;
    int          v0, e0;
    logic [15:0] last;

    $display("[TB] reset");
    repeat (5) @(negedge clk);
    checkOutput("reset_led", {16'h0, led}, 32'h0);
    checkOutput("reset_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("reset_valid", {31'h0, frame_valid}, 32'h0);
    checkOutput("reset_err", {31'h0, frame_err}, 32'h0);
    checkOutput("reset_wdog", {31'h0, wdog_timeout}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] first frame");
    applyStimulus(32'hA5C3, 16, HALF10, rd);
    checkOutput("f1_led", {16'h0, led}, 32'hA5C3);
    checkOutput("f1_readback", rd, 32'h0);
    checkOutput("f1_valid_pulses", valid_count, 1);
    checkOutput("f1_err_pulses", err_count, 0);
    checkOutput("idle_miso", {31'h0, spi_miso}, 32'h0);

    $display("[TB] second frame");
    applyStimulus(32'h1234, 16, HALF10, rd);
    checkOutput("f2_readback", rd, 32'hA5C3);
    checkOutput("f2_led", {16'h0, led}, 32'h1234);
    checkOutput("f2_valid_pulses", valid_count, 2);

    $display("[TB] bad lengths");
    applyStimulus(32'h7ABC, 15, HALF10, rd);
    checkOutput("short_readback", rd, 32'h091A);
    checkOutput("short_led", {16'h0, led}, 32'h1234);
    checkOutput("short_err_pulses", err_count, 1);
    applyStimulus(32'h1FFFF, 17, HALF10, rd);
    checkOutput("long_readback", rd, 32'h2468);
    checkOutput("long_led", {16'h0, led}, 32'h1234);
    checkOutput("long_err_pulses", err_count, 2);
    applyStimulus(32'h0, 0, HALF10, rd);
    checkOutput("zero_err_pulses", err_count, 3);
    checkOutput("bad_valid_pulses", valid_count, 2);

    $display("[TB] reset mid-frame");
    v0 = valid_count;
    e0 = err_count;
    spi_cs_n = 1'b0;
    shiftBits(32'hFFFF, 8, HALF10, rd);
    rst_n = 1'b0;
    #30;
    checkOutput("midrst_led", {16'h0, led}, 32'h0);
    checkOutput("midrst_miso", {31'h0, spi_miso}, 32'h0);
    #20;
    rst_n = 1'b1;
    shiftBits(32'hFF, 8, HALF10, rd);
    #HALF10;
    spi_cs_n = 1'b1;
    #200;
    checkOutput("midrst_no_valid", valid_count, v0);
    checkOutput("midrst_no_err", err_count, e0);
    applyStimulus(32'h00FF, 16, HALF10, rd);
    checkOutput("postrst_led", {16'h0, led}, 32'h00FF);
    checkOutput("postrst_readback", rd, 32'h0);
    checkOutput("postrst_valid", valid_count, v0 + 1);

    $display("[TB] 200 random frames at 12.5 MHz");
    v0   = valid_count;
    last = 16'h00FF;
    for (int n = 0; n < 200; n++) begin
      word = 16'($urandom);
      #($urandom_range(0, 9));
      applyStimulus({16'h0, word}, 16, HALF12, rd);
      checkOutput("rand_readback", rd, {16'h0, last});
      checkOutput("rand_led", {16'h0, led}, {16'h0, word});
      last = word;
    end
    checkOutput("rand_valid_pulses", valid_count, v0 + 200);

    $display("[TB] watchdog");
    repeat (WDOG + 100) @(negedge clk);
`ifdef SPI_WDOG_EN
    checkOutput("wdog_active", {31'h0, wdog_timeout}, 32'h1);
    model = cyc;
    checkOutput("wdog_fallback", {16'h0, led}, {16'h0, model[26:12], model[26]});
    repeat (5000) @(negedge clk);
    model = cyc;
    checkOutput("wdog_scroll", {16'h0, led}, {16'h0, model[26:12], model[26]});
    applyStimulus(32'hBEEF, 16, HALF10, rd);
    checkOutput("wdog_readback", rd, {16'h0, last});
    checkOutput("wdog_cleared", {31'h0, wdog_timeout}, 32'h0);
    checkOutput("wdog_led", {16'h0, led}, 32'hBEEF);
`else
    model = {16'h0, last};
    checkOutput("nowdog_flag", {31'h0, wdog_timeout}, 32'h0);
    checkOutput("nowdog_led_hold", {16'h0, led}, model);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
